// File: rtl/mips_pkg.sv
// Shared definitions for the P7 data-memory access path: size and
// exception encodings, the access FSM states, address windows and
// store-side lane helpers.
package mips_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [31:0] DM_LIMIT_DEF  = 32'h0000_3000;
    localparam logic [31:0] DEV_BASE_DEF  = 32'h0000_7F00;
    localparam logic [31:0] DEV_LIMIT_DEF = 32'h0000_7F24;
    localparam int          WAIT_MAX_DEF  = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } dm_state_e;

    // Write byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] dm_byteen(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_B:    be = 4'b0001 << offs;
            SZ_H:    be = offs[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data into every lane it may occupy.
    function automatic logic [31:0] dm_wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        unique case (size)
            SZ_B:    rep = {4{wdata[7:0]}};
            SZ_H:    rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load-data lane selection: picks the byte/half/word addressed by the
// low address bits out of the memory word and sign- or zero-extends it.
module dm_lane_ext
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offs_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane mux followed by extension according to access size.
    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (offs_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offs_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (size_i)
            SZ_B:    data_o = sign_i ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            SZ_H:    data_o = sign_i ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory initiator for the P7 M-stage: one load/store at a time,
// legality check, single-cycle write strobe on mem_ready, load alignment,
// and AdEL/AdES/DBE reporting.
// Build option: DM_MISALIGN_EXC_EN -- when defined, misaligned half/word
// accesses raise an address error; otherwise the low address bits are
// silently cleared for half/word accesses.
module dm_access_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT  = DM_LIMIT_DEF,
    parameter logic [31:0] DEV_BASE  = DEV_BASE_DEF,
    parameter logic [31:0] DEV_LIMIT = DEV_LIMIT_DEF,
    parameter int          WAIT_MAX  = WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [4:0]  resp_exccode,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    input  logic        mem_ready
);

    // Last counter value before timeout: WAIT_MAX ready-low ACCESS cycles.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    dm_state_e   state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;
    logic [4:0]  code_q, code_d;

    logic [31:0] eff_addr;
    logic        misal;
    logic        in_dm, in_dev, size_bad, dev_narrow_st, req_ok;
    logic [31:0] ld_data;

    // Effective request address and misalignment detection.
    always_comb begin
        eff_addr = req_addr;
`ifdef DM_MISALIGN_EXC_EN
        misal = ((req_size == SZ_H) && req_addr[0]) ||
                ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
        if (req_size == SZ_H) eff_addr[0]   = 1'b0;
        if (req_size == SZ_W) eff_addr[1:0] = 2'b00;
`endif
    end

    // Request legality: size, address window, narrow device stores, alignment.
    always_comb begin
        in_dm         = eff_addr < DM_LIMIT;
        in_dev        = (eff_addr >= DEV_BASE) && (eff_addr < DEV_LIMIT);
        size_bad      = req_size == 2'd3;
        dev_narrow_st = in_dev && req_we && (req_size != SZ_W);
        req_ok        = !size_bad && (in_dm || in_dev) && !dev_narrow_st && !misal;
    end

    dm_lane_ext u_lane_ext (
        .rdata_i (m_data_rdata),
        .offs_i  (addr_q[1:0]),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .data_o  (ld_data)
    );

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            exc_q   <= 1'b0;
            code_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic: capture in IDLE, wait/timeout in ACCESS, one-cycle RESP.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        code_d  = code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    addr_d  = eff_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'd0;
                    rdata_d = 32'd0;
                    if (req_ok) begin
                        state_d = ST_ACCESS;
                        exc_d   = 1'b0;
                        code_d  = 5'd0;
                    end else begin
                        state_d = ST_RESP;
                        exc_d   = 1'b1;
                        code_d  = req_we ? EXC_ADES : EXC_ADEL;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    exc_d   = 1'b0;
                    code_d  = 5'd0;
                    rdata_d = we_q ? 32'd0 : ld_data;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    exc_d   = 1'b1;
                    code_d  = EXC_DBE;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                // Response fields read as zero outside the RESP pulse.
                state_d = ST_IDLE;
                exc_d   = 1'b0;
                code_d  = 5'd0;
                rdata_d = 32'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and response outputs; the write strobe exists only on the ready cycle.
    always_comb begin
        busy          = state_q != ST_IDLE;
        resp_valid    = state_q == ST_RESP;
        resp_rdata    = rdata_q;
        resp_exc      = exc_q;
        resp_exccode  = code_q;
        m_data_addr   = {addr_q[31:2], 2'b00};
        m_data_wdata  = dm_wdata_rep(size_q, wdata_q);
        m_data_byteen = 4'b0000;
        if ((state_q == ST_ACCESS) && we_q && mem_ready)
            m_data_byteen = dm_byteen(size_q, addr_q[1:0]);
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: expected responses are queued when
// a request is driven and compared when resp_valid appears.
module tb_dm_access_unit;
    import mips_pkg::*;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] rdata;
        bit          bus;
        logic [3:0]  be;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_sign, mem_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, m_data_rdata;
    logic        busy, resp_valid, resp_exc;
    logic [31:0] resp_rdata, m_data_addr, m_data_wdata;
    logic [4:0]  resp_exccode;
    logic [3:0]  m_data_byteen;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dm_access_unit dut (
        .clk           (clk),
        .reset         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_sign      (req_sign),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_exc      (resp_exc),
        .resp_exccode  (resp_exccode),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .mem_ready     (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t mk_exp(input logic exc, input logic [4:0] code, input logic [31:0] rdata,
                                    input bit bus, input logic [3:0] be, input logic [31:0] waddr,
                                    input logic [31:0] wdata, input int lat);
        exp_t e;
        e.exc = exc; e.code = code; e.rdata = rdata; e.bus = bus;
        e.be = be; e.waddr = waddr; e.wdata = wdata; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t exc_exp(input logic [4:0] code);
        return mk_exp(1'b1, code, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0);
    endfunction

    // Drive one request, play memory with a ready delay, then score the response.
    task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int dly, input exp_t e);
        exp_t        x;
        int          lat, nwr;
        bit          got;
        logic [3:0]  be_seen;
        logic [31:0] wa_seen, wd_seen, addr_seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
        req_addr = addr; req_wdata = wd; m_data_rdata = rd; mem_ready = (dly == 0);
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hDEAD_BEE0; req_wdata = $urandom; req_size = 2'($urandom);
        got = 0; lat = 0; nwr = 0; be_seen = 0; wa_seen = 0; wd_seen = 0; addr_seen = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 0) addr_seen = m_data_addr;
            if (m_data_byteen != 4'd0) begin
                nwr++; be_seen = m_data_byteen; wa_seen = m_data_addr; wd_seen = m_data_wdata;
            end
            if (resp_valid) begin
                got = 1; lat = k;
            end else begin
                @(posedge clk); #1;
                mem_ready = (k + 1 >= dly);
            end
        end
        mem_ready = 1'b0;
        x = sb_q.pop_front();
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_exc"}, 32'(resp_exc), 32'(x.exc));
            check({tag, "_code"}, 32'(resp_exccode), 32'(x.code));
            check({tag, "_rdata"}, resp_rdata, x.rdata);
            check({tag, "_lat"}, 32'(lat), 32'(x.lat));
            check({tag, "_nwrites"}, 32'(nwr), (x.bus && we) ? 32'd1 : 32'd0);
            if (x.bus) check({tag, "_addr"}, addr_seen, x.waddr);
            if (x.bus && we) begin
                check({tag, "_be"}, 32'(be_seen), 32'(x.be));
                check({tag, "_waddr"}, wa_seen, x.waddr);
                check({tag, "_wdata"}, wd_seen, x.wdata);
            end
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_pulse_end"}, {30'd0, resp_valid, busy}, 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_exc"}, {26'd0, resp_exc, resp_exccode}, 32'd0);
        check({tag, "_maddr"}, m_data_addr, 32'd0);
        check({tag, "_mwdata"}, m_data_wdata, 32'd0);
        check({tag, "_be"}, 32'(m_data_byteen), 32'd0);
    endtask

    initial begin
        bit   seen;
        exp_t e;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; m_data_rdata = 32'd0; mem_ready = 1'b0;
        #13;
        check_idle_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Stores and loads from the basic plan.
        run_req("sw_10", 1, SZ_W, 0, 32'h10, 32'h1234_5678, 32'h0, 0,
                mk_exp(0, 0, 0, 1, 4'b1111, 32'h10, 32'h1234_5678, 1));
        run_req("sb_13", 1, SZ_B, 0, 32'h13, 32'h0000_00AB, 32'h0, 0,
                mk_exp(0, 0, 0, 1, 4'b1000, 32'h10, 32'hABAB_ABAB, 1));
        run_req("lb_13s", 0, SZ_B, 1, 32'h13, 32'h0, 32'hAB00_0000, 0,
                mk_exp(0, 0, 32'hFFFF_FFAB, 1, 0, 32'h10, 0, 1));
        run_req("lh_2z", 0, SZ_H, 0, 32'h2, 32'h0, 32'h8001_0000, 0,
                mk_exp(0, 0, 32'h0000_8001, 1, 0, 32'h0, 0, 1));
        run_req("lh_2s", 0, SZ_H, 1, 32'h2, 32'h0, 32'h8001_0000, 0,
                mk_exp(0, 0, 32'hFFFF_8001, 1, 0, 32'h0, 0, 1));
        run_req("lb_1z", 0, SZ_B, 0, 32'h1, 32'h0, 32'h0000_9C00, 0,
                mk_exp(0, 0, 32'h0000_009C, 1, 0, 32'h0, 0, 1));
        run_req("sh_2e_dly3", 1, SZ_H, 0, 32'h2E, 32'hFFFF_1234, 32'h0, 3,
                mk_exp(0, 0, 0, 1, 4'b1100, 32'h2C, 32'h1234_1234, 4));

        // Misaligned accesses depend on the build option.
`ifdef DM_MISALIGN_EXC_EN
        run_req("lw_6", 0, SZ_W, 0, 32'h6, 32'h0, 32'hCAFE_F00D, 0, exc_exp(EXC_ADEL));
        run_req("lh_5", 0, SZ_H, 1, 32'h5, 32'h0, 32'h1234_ABCD, 0, exc_exp(EXC_ADEL));
`else
        run_req("lw_6", 0, SZ_W, 0, 32'h6, 32'h0, 32'hCAFE_F00D, 0,
                mk_exp(0, 0, 32'hCAFE_F00D, 1, 0, 32'h4, 0, 1));
        run_req("lh_5", 0, SZ_H, 1, 32'h5, 32'h0, 32'h1234_ABCD, 0,
                mk_exp(0, 0, 32'hFFFF_ABCD, 1, 0, 32'h4, 0, 1));
`endif

        // Window, size and device-store boundaries.
        run_req("sb_7f00", 1, SZ_B, 0, 32'h7F00, 32'h55, 32'h0, 0, exc_exp(EXC_ADES));
        run_req("sw_4000", 1, SZ_W, 0, 32'h4000, 32'h55, 32'h0, 0, exc_exp(EXC_ADES));
        run_req("lw_7f20", 0, SZ_W, 0, 32'h7F20, 32'h0, 32'h0000_0042, 0,
                mk_exp(0, 0, 32'h42, 1, 0, 32'h7F20, 0, 1));
        run_req("lw_3000", 0, SZ_W, 0, 32'h3000, 32'h0, 32'h1, 0, exc_exp(EXC_ADEL));
        run_req("lw_7f24", 0, SZ_W, 0, 32'h7F24, 32'h0, 32'h1, 0, exc_exp(EXC_ADEL));
        run_req("lb_2fff", 0, SZ_B, 0, 32'h2FFF, 32'h0, 32'h7700_0000, 0,
                mk_exp(0, 0, 32'h77, 1, 0, 32'h2FFC, 0, 1));
        run_req("size3", 0, 2'd3, 0, 32'h0, 32'h0, 32'h1, 0, exc_exp(EXC_ADEL));
        run_req("sw_7f04", 1, SZ_W, 0, 32'h7F04, 32'hA5A5_0F0F, 32'h0, 2,
                mk_exp(0, 0, 0, 1, 4'b1111, 32'h7F04, 32'hA5A5_0F0F, 3));

        // Bus timeout: ready never arrives inside the wait budget.
        run_req("lw_timeout", 0, SZ_W, 0, 32'h100, 32'h0, 32'h1, 20,
                mk_exp(1, EXC_DBE, 0, 1, 0, 32'h100, 0, WAIT_MAX_DEF));

        // A request still asserted during RESP must be ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_addr = 32'h7F00;
        sb_q.push_back(exc_exp(EXC_ADES));
        @(posedge clk); #1;
        req_size = SZ_W; req_addr = 32'h20; mem_ready = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        check("resp_hold_valid", 32'(resp_valid), 32'd1);
        check("resp_hold_code", 32'(resp_exccode), 32'(e.code));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("resp_hold_ignored", {30'd0, busy, |m_data_byteen}, 32'd0);
        mem_ready = 1'b0;

        // Reset in the middle of a stalled store aborts it with no write.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h140;
        req_wdata = 32'h5555_AAAA; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || (m_data_byteen != 4'd0)) seen = 1;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        mem_ready = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
